ram_req_ctrl: RTL and testbench

RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

---
 rtl/ram_req_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ram_req_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: single-port word RAM behind a valid/ready request channel
// and a valid/ready read-response channel.
// After reset an INIT sequence clears every word, one address per cycle,
// and then raises init_done. A read answers one cycle after it is accepted,
// and the response is held until the consumer takes it. While a response is
// completing, the next request can be accepted in the same cycle.
// Optional build macro RAM_PARITY_EN adds a stored even-parity bit per word.
// rsp_err flags a parity mismatch on the response.
// par_flip corrupts the stored parity bit on a write, so the error path can
// be exercised. Without the macro, par_flip is ignored and rsp_err is 0.
module ram_req_ctrl #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  init_done,
   input  logic                  par_flip,
   output logic                  rsp_err
);

`ifdef RAM_PARITY_EN
   localparam int WORD_W = DATA_WIDTH + 1;

   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data);
      return ^data;
   endfunction
`else
   localparam int WORD_W = DATA_WIDTH;
`endif

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      RESP = 2'd2
   } state_t;

   logic [WORD_W-1:0]     mem_r [DEPTH];
   state_t                state_r,     state_nxt_s;
   logic [ADDR_WIDTH-1:0] clr_cnt_r,   clr_cnt_nxt_s;
   logic                  init_done_r, init_done_nxt_s;
   logic                  rsp_valid_r, rsp_valid_nxt_s;
   logic [DATA_WIDTH-1:0] rsp_data_r,  rsp_data_nxt_s;
   logic                  rsp_err_r,   rsp_err_nxt_s;
   logic                  req_ready_s;
   logic                  mem_we_s;
   logic [ADDR_WIDTH-1:0] mem_addr_s;
   logic [WORD_W-1:0]     mem_wdata_s;
   logic [WORD_W-1:0]     mem_q_s;
   logic [WORD_W-1:0]     wr_word_s;
   logic                  rd_err_s;

   assign mem_q_s = mem_r[req_addr];

`ifdef RAM_PARITY_EN
   assign wr_word_s = {calc_parity(req_wdata) ^ par_flip, req_wdata};
   assign rd_err_s  = mem_q_s[DATA_WIDTH] != calc_parity(mem_q_s[DATA_WIDTH-1:0]);
`else
   logic unused_par_flip_s;
   assign unused_par_flip_s = par_flip;
   assign wr_word_s         = req_wdata;
   assign rd_err_s          = 1'b0;
`endif

   // Next-state, memory-port and next-output decode for the INIT/IDLE/RESP FSM.
   always_comb begin
      state_nxt_s     = state_r;
      clr_cnt_nxt_s   = clr_cnt_r;
      init_done_nxt_s = init_done_r;
      rsp_valid_nxt_s = rsp_valid_r;
      rsp_data_nxt_s  = rsp_data_r;
      rsp_err_nxt_s   = rsp_err_r;
      req_ready_s     = 1'b0;
      mem_we_s        = 1'b0;
      mem_addr_s      = req_addr;
      mem_wdata_s     = wr_word_s;
      case (state_r)
         INIT: begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_cnt_r;
            mem_wdata_s = {WORD_W{1'b0}};
            if (clr_cnt_r == LAST_ADDR) begin
               state_nxt_s     = IDLE;
               clr_cnt_nxt_s   = {ADDR_WIDTH{1'b0}};
               init_done_nxt_s = 1'b1;
            end else begin
               clr_cnt_nxt_s = clr_cnt_r + ADDR_WIDTH'(1);
            end
         end
         IDLE: begin
            req_ready_s = 1'b1;
            if (req_valid && req_we) begin
               mem_we_s = 1'b1;
            end else if (req_valid) begin
               state_nxt_s     = RESP;
               rsp_valid_nxt_s = 1'b1;
               rsp_data_nxt_s  = mem_q_s[DATA_WIDTH-1:0];
               rsp_err_nxt_s   = rd_err_s;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RESP: begin
            // The response retires in the same cycle that frees the request port.
            req_ready_s = rsp_ready;
            if (rsp_ready && req_valid && !req_we) begin
               rsp_data_nxt_s = mem_q_s[DATA_WIDTH-1:0];
               rsp_err_nxt_s  = rd_err_s;
            end else if (rsp_ready) begin
               mem_we_s        = req_valid;
               state_nxt_s     = IDLE;
               rsp_valid_nxt_s = 1'b0;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: begin
            state_nxt_s = INIT;
         end
      endcase
   end

   // Control and response registers; reset discards any pending response and restarts the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= INIT;
         clr_cnt_r   <= {ADDR_WIDTH{1'b0}};
         init_done_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= {DATA_WIDTH{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         clr_cnt_r   <= clr_cnt_nxt_s;
         init_done_r <= init_done_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
         rsp_data_r  <= rsp_data_nxt_s;
         rsp_err_r   <= rsp_err_nxt_s;
      end
   end

   // Storage array: a single write per cycle; its contents are set by the INIT clear, not by reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[mem_addr_s] <= mem_wdata_s;
      end
   end

   assign req_ready = req_ready_s;
   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_err   = rsp_err_r;
   assign init_done = init_done_r;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed testbench for ram_req_ctrl (default 64 x 8 configuration).
// The expected values are constants worked out by hand.
// When RAM_PARITY_EN is defined, the parity-error expectation follows it.
module tb_ram_req_ctrl;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_we;
   logic [5:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       init_done;
   logic       par_flip;
   logic       rsp_err;

   int checks_cnt;
   int errors_cnt;
   int cyc;

   ram_req_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DEPTH(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .init_done (init_done),
      .par_flip  (par_flip),
      .rsp_err   (rsp_err)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Count edges after reset release until init_done rises, bounded.
   task automatic wait_init(input string tag);
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (init_done) break;
      end
      check_val(tag, 32'(cyc), 32'd64);
      check_val({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
   endtask

   task automatic do_write(input logic [5:0] addr, input logic [7:0] data, input logic flip);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = addr;
      req_wdata = data;
      par_flip  = flip;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      par_flip  = 1'b0;
      check_val("wr_no_rsp", {31'd0, rsp_valid}, 32'd0);
   endtask

   task automatic do_read(input string tag, input logic [5:0] addr, input logic [7:0] exp, input logic exp_err);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = addr;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_val({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
      check_val({tag, "_data"}, {24'd0, rsp_data}, {24'd0, exp});
      check_val({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      @(posedge clk); #1;
      check_val({tag, "_drop"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   logic exp_flip_err;

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
`ifdef RAM_PARITY_EN
      exp_flip_err = 1'b1;
`else
      exp_flip_err = 1'b0;
`endif
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 6'd0;
      req_wdata = 8'd0;
      rsp_ready = 1'b1;
      par_flip  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_ready", {31'd0, req_ready}, 32'd0);
      check_val("rst_valid", {31'd0, rsp_valid}, 32'd0);
      check_val("rst_data", {24'd0, rsp_data}, 32'd0);
      check_val("rst_init_done", {31'd0, init_done}, 32'd0);
      check_val("rst_err", {31'd0, rsp_err}, 32'd0);
      rst_n = 1'b1;
      wait_init("init_cycles");

      // Back-to-back reads of every address: each returns the cleared value.
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 6'd0;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk); #1;
         check_val("clr_vld", {31'd0, rsp_valid}, 32'd1);
         check_val("clr_data", {24'd0, rsp_data}, 32'd0);
         if (i == 63) req_valid = 1'b0;
         else req_addr = 6'(i + 1);
      end
      @(posedge clk); #1;
      check_val("clr_drop", {31'd0, rsp_valid}, 32'd0);

      // Three writes, then three pipelined reads at one response per cycle.
      do_write(6'd0, 8'hf0, 1'b0);
      do_write(6'd1, 8'he1, 1'b0);
      do_write(6'd2, 8'hd2, 1'b0);
      req_valid = 1'b1;
      req_addr  = 6'd0;
      @(posedge clk); #1;
      check_val("pipe0", {24'd0, rsp_data}, 32'h0f0);
      check_val("pipe0_vld", {31'd0, rsp_valid}, 32'd1);
      req_addr = 6'd1;
      @(posedge clk); #1;
      check_val("pipe1", {24'd0, rsp_data}, 32'h0e1);
      check_val("pipe1_vld", {31'd0, rsp_valid}, 32'd1);
      req_addr = 6'd2;
      @(posedge clk); #1;
      check_val("pipe2", {24'd0, rsp_data}, 32'h0d2);
      check_val("pipe2_vld", {31'd0, rsp_valid}, 32'd1);
      req_valid = 1'b0;
      @(posedge clk); #1;
      check_val("pipe_drop", {31'd0, rsp_valid}, 32'd0);

      // Back-pressure: response held, pending request blocked until rsp_ready.
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr  = 6'd1;
      @(posedge clk); #1;
      check_val("stall_first", {24'd0, rsp_data}, 32'h0e1);
      req_addr = 6'd2;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_val("stall_data", {24'd0, rsp_data}, 32'h0e1);
         check_val("stall_vld", {31'd0, rsp_valid}, 32'd1);
         check_val("stall_rdy", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      #1;
      check_val("stall_release_rdy", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      check_val("stall_next", {24'd0, rsp_data}, 32'h0d2);
      check_val("stall_next_vld", {31'd0, rsp_valid}, 32'd1);
      req_valid = 1'b0;
      @(posedge clk); #1;
      check_val("stall_drop", {31'd0, rsp_valid}, 32'd0);

      // Read immediately after write to the same address.
      do_write(6'd7, 8'h5a, 1'b0);
      do_read("raw7", 6'd7, 8'h5a, 1'b0);
      do_read("hi63", 6'd63, 8'h00, 1'b0);

      // Parity: corrupted stored parity flags an error only in the parity build.
      do_write(6'd9, 8'h03, 1'b1);
      do_read("par_flip", 6'd9, 8'h03, exp_flip_err);
      do_write(6'd10, 8'h03, 1'b0);
      do_read("par_ok", 6'd10, 8'h03, 1'b0);

      // Reset while a response is pending.
      do_write(6'd5, 8'h77, 1'b0);
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr  = 6'd5;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_val("pre_rst_vld", {31'd0, rsp_valid}, 32'd1);
      check_val("pre_rst_data", {24'd0, rsp_data}, 32'h077);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_vld", {31'd0, rsp_valid}, 32'd0);
      check_val("async_rst_data", {24'd0, rsp_data}, 32'd0);
      check_val("async_rst_rdy", {31'd0, req_ready}, 32'd0);
      check_val("async_rst_init", {31'd0, init_done}, 32'd0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      wait_init("reinit_cycles");
      do_read("rerun5", 6'd5, 8'h00, 1'b0);
      do_read("rerun0", 6'd0, 8'h00, 1'b0);
      do_read("rerun9", 6'd9, 8'h00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
